oser_serializer: RTL



---
 rtl/oser_serializer.sv | 89 ++++++++
 1 files changed

// File: rtl/oser_serializer.sv
// N:1 output serializer: one parallel word per lane every RATIO bit clocks, shifted out LSB-first.
// Latency: bit 0 appears the cycle after acceptance; din_ready is a fixed slot strobe, and a stall inserts IDLE_WORD.
module oser_serializer #(
  parameter int          RATIO     = 10,
  parameter int          LANES     = 3,
  parameter logic [15:0] IDLE_WORD = 16'h0354,
  parameter int          CNT_W     = 16
) (
  input  logic                   clkin,
  input  logic                   resetn,
  input  logic [LANES*RATIO-1:0] din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [LANES-1:0]       q,
  output logic                   word_start,
  output logic                   underrun,
  output logic [CNT_W-1:0]       underrun_cnt,
  input  logic                   clr_underrun
);

  localparam int BW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BW-1:0] LAST = BW'(RATIO - 1);

  logic [BW-1:0]                  bcnt_q, bcnt_d;
  logic [LANES-1:0][RATIO-1:0]    shreg_q, shreg_d;
  logic                           started_q, started_d;
  logic                           word_start_q, word_start_d;
  logic                           underrun_q, underrun_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           load;
  logic                           evt;

  always_comb begin
    load         = (bcnt_q == LAST);
    bcnt_d       = load ? '0 : bcnt_q + BW'(1);
    // Only stalls after the first real word count as underruns.
    evt          = load & ~din_valid & started_q;
    started_d    = started_q | (load & din_valid);
    word_start_d = load;
    underrun_d   = evt;

    shreg_d = shreg_q;
    for (int k = 0; k < LANES; k++) begin
      if (load) begin
        shreg_d[k] = din_valid ? din[k*RATIO +: RATIO] : IDLE_WORD[RATIO-1:0];
      end else begin
        shreg_d[k] = {1'b0, shreg_q[k][RATIO-1:1]};
      end
    end

    cnt_d = cnt_q;
    if (clr_underrun) begin
      cnt_d = evt ? CNT_W'(1) : '0;
    end else if (evt && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      bcnt_q       <= LAST;
      shreg_q      <= '0;
      started_q    <= 1'b0;
      word_start_q <= 1'b0;
      underrun_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      bcnt_q       <= bcnt_d;
      shreg_q      <= shreg_d;
      started_q    <= started_d;
      word_start_q <= word_start_d;
      underrun_q   <= underrun_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    q = '0;
    for (int k = 0; k < LANES; k++) begin
      q[k] = shreg_q[k][0];
    end
  end

  assign din_ready    = load;
  assign word_start   = word_start_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = cnt_q;

endmodule
